// File: rtl/m2vrefaddr_pkg.sv
// ---------------------------------------------------------------------------
// m2vrefaddr_pkg
//   Shared definitions for the motion-compensation reference-fetch address
//   generator: block codes, FSM state encoding, words-per-pixel packing and
//   the words-per-row helper used by the coordinate stage.
// ---------------------------------------------------------------------------
package m2vrefaddr_pkg;

    // Block codes carried on s1_block (0-3 are the luma quadrants)
    localparam logic [2:0] BLK_CB   = 3'd4;
    localparam logic [2:0] BLK_CR   = 3'd5;
    localparam logic [2:0] BLK_LAST = BLK_CR;

    // One 32-bit memory word packs four 8-bit pixels
    localparam int WORD_PIXELS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_REQ  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Words touched by one row: 8 pixels (+1 for half-pel) starting at
    // pixel offset xoff inside the first word.  Result is 2 or 3.
    function automatic logic [1:0] words_per_row(input logic [1:0] xoff,
                                                 input logic       hx);
        logic [3:0] last_pix;
        last_pix = {2'b00, xoff} + 4'd7 + {3'b000, hx};
        return last_pix[3:2] + 2'd1;
    endfunction

endpackage

// File: rtl/m2vrefaddr_coord.sv
// ---------------------------------------------------------------------------
// m2vrefaddr_coord
//   Combinational MV scale/split and reference coordinate calculation.
//   Produces the word address of the first fetch, the row pitch of the
//   selected plane, half-pel flags, sub-word offset and words per row.
//   Optional macro M2V_REFADDR_CLAMP_EN clamps x/y into the picture before
//   any address, word-count or offset derivation.
// Ports
//   blk         in   3            block code (0-3 luma, 4 Cb, 5 Cr)
//   mb_x, mb_y  in   MBX/MBY      macroblock column / row
//   mv_h, mv_v  in   MVH/MVV      signed motion vector, half-pel units
//   start_addr  out  ADDR_WIDTH   word address of row 0, word 0
//   pitch       out  ADDR_WIDTH   words per picture row of the plane
//   hx, hy      out  1            half-pel flags
//   xoff        out  2            pixel offset within first word
//   words       out  2            words per row (2 or 3)
// ---------------------------------------------------------------------------
module m2vrefaddr_coord
    import m2vrefaddr_pkg::*;
#(
    parameter int MVH_WIDTH  = 12,
    parameter int MVV_WIDTH  = 12,
    parameter int MBX_WIDTH  = 6,
    parameter int MBY_WIDTH  = 6,
    parameter int FRAME_MBW  = 45,
    parameter int FRAME_MBH  = 36,
    parameter int ADDR_WIDTH = 18
) (
    input  logic        [2:0]            blk,
    input  logic        [MBX_WIDTH-1:0]  mb_x,
    input  logic        [MBY_WIDTH-1:0]  mb_y,
    input  logic signed [MVH_WIDTH-1:0]  mv_h,
    input  logic signed [MVV_WIDTH-1:0]  mv_v,
    output logic        [ADDR_WIDTH-1:0] start_addr,
    output logic        [ADDR_WIDTH-1:0] pitch,
    output logic                         hx,
    output logic                         hy,
    output logic        [1:0]            xoff,
    output logic        [1:0]            words
);

    localparam int XW     = MBX_WIDTH + 6;
    localparam int YW     = MBY_WIDTH + 6;
    localparam int XSHIFT = $clog2(WORD_PIXELS);

    localparam logic [ADDR_WIDTH-1:0] CB_BASE = ADDR_WIDTH'(FRAME_MBW * FRAME_MBH * 64);
    localparam logic [ADDR_WIDTH-1:0] CR_BASE = ADDR_WIDTH'(FRAME_MBW * FRAME_MBH * 80);

    logic                         chroma;
    logic signed [MVH_WIDTH-1:0]  mvh_bias, mvh_sel, int_h;
    logic signed [MVV_WIDTH-1:0]  mvv_bias, mvv_sel, int_v;
    logic signed [XW-1:0]         x_base, x_raw, x_clip, x_word;
    logic signed [YW-1:0]         y_base, y_raw, y_clip;
    logic        [ADDR_WIDTH-1:0] base, x_ext, y_ext;
`ifdef M2V_REFADDR_CLAMP_EN
    logic signed [XW-1:0]         x_lim;
    logic signed [YW-1:0]         y_lim;
`endif

    always_comb begin
        chroma = (blk == BLK_CB) || (blk == BLK_CR);

        // Chroma halving truncates toward zero: bias negatives by +1, then
        // arithmetic shift (-3 -> -1, 3 -> 1).
        mvh_bias = mv_h + $signed({{(MVH_WIDTH-1){1'b0}}, mv_h[MVH_WIDTH-1]});
        mvv_bias = mv_v + $signed({{(MVV_WIDTH-1){1'b0}}, mv_v[MVV_WIDTH-1]});
        mvh_sel  = chroma ? (mvh_bias >>> 1) : mv_h;
        mvv_sel  = chroma ? (mvv_bias >>> 1) : mv_v;

        hx    = mvh_sel[0];
        hy    = mvv_sel[0];
        int_h = mvh_sel >>> 1;
        int_v = mvv_sel >>> 1;

        if (chroma) begin
            x_base = XW'({mb_x, 3'b000});
            y_base = YW'({mb_y, 3'b000});
            base   = (blk == BLK_CB) ? CB_BASE : CR_BASE;
            pitch  = ADDR_WIDTH'(FRAME_MBW * 2);
        end else begin
            // mb*16 + quadrant*8 is just a concatenation
            x_base = XW'({mb_x, blk[0], 3'b000});
            y_base = YW'({mb_y, blk[1], 3'b000});
            base   = '0;
            pitch  = ADDR_WIDTH'(FRAME_MBW * 4);
        end

        x_raw = x_base + XW'(int_h);
        y_raw = y_base + YW'(int_v);

`ifdef M2V_REFADDR_CLAMP_EN
        x_lim = (chroma ? XW'(FRAME_MBW * 8 - 8) : XW'(FRAME_MBW * 16 - 8)) - XW'(hx);
        y_lim = (chroma ? YW'(FRAME_MBH * 8 - 8) : YW'(FRAME_MBH * 16 - 8)) - YW'(hy);
        if (x_raw[XW-1])      x_clip = '0;
        else if (x_raw > x_lim) x_clip = x_lim;
        else                  x_clip = x_raw;
        if (y_raw[YW-1])      y_clip = '0;
        else if (y_raw > y_lim) y_clip = y_lim;
        else                  y_clip = y_raw;
`else
        x_clip = x_raw;
        y_clip = y_raw;
`endif

        xoff  = x_clip[1:0];
        words = words_per_row(xoff, hx);

        // Sign-extend into the address width; everything after is modulo 2^ADDR_WIDTH
        x_word     = x_clip >>> XSHIFT;
        x_ext      = {{(ADDR_WIDTH-XW){x_word[XW-1]}}, x_word};
        y_ext      = {{(ADDR_WIDTH-YW){y_clip[YW-1]}}, y_clip};
        start_addr = base + y_ext * pitch + x_ext;
    end

endmodule

// File: rtl/m2vrefaddr.sv
// ---------------------------------------------------------------------------
// m2vrefaddr
//   Reference-fetch address generator for motion compensation.  On start it
//   captures the s1 block context (in CALC), then issues a row-major sequence
//   of word reads (rows = 8+hy, words = 2/3 per row) with a stall handshake.
//   Intra blocks, I-pictures, disabled slots and invalid block codes skip
//   straight to a done pulse.
//   Optional macro M2V_REFADDR_CLAMP_EN: clamp reference coordinates into
//   the picture (see m2vrefaddr_coord); default build wraps instead.
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   start               pulse: s1_* just updated
//   sa_iframe, s1_*     picture type and block context
//   rd_addr, rd_req     read address / request, held until !rd_wait
//   rd_wait             memory stall
//   pf_hx, pf_hy        half-pel flags for the interpolator
//   pf_xoff, pf_words   sub-word offset and words per row
//   busy, done          FSM not idle / 1-clk completion pulse
//   err_overrun         sticky: start while busy
// ---------------------------------------------------------------------------
module m2vrefaddr
    import m2vrefaddr_pkg::*;
#(
    parameter int MVH_WIDTH  = 12,
    parameter int MVV_WIDTH  = 12,
    parameter int MBX_WIDTH  = 6,
    parameter int MBY_WIDTH  = 6,
    parameter int FRAME_MBW  = 45,
    parameter int FRAME_MBH  = 36,
    parameter int ADDR_WIDTH = 18
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         sa_iframe,
    input  logic                         s1_enable,
    input  logic                         s1_mb_intra,
    input  logic        [2:0]            s1_block,
    input  logic        [MBX_WIDTH-1:0]  s1_mb_x,
    input  logic        [MBY_WIDTH-1:0]  s1_mb_y,
    input  logic signed [MVH_WIDTH-1:0]  s1_mv_h,
    input  logic signed [MVV_WIDTH-1:0]  s1_mv_v,
    output logic        [ADDR_WIDTH-1:0] rd_addr,
    output logic                         rd_req,
    input  logic                         rd_wait,
    output logic                         pf_hx,
    output logic                         pf_hy,
    output logic        [1:0]            pf_xoff,
    output logic        [1:0]            pf_words,
    output logic                         busy,
    output logic                         done,
    output logic                         err_overrun
);

    state_t                  state_q, state_d;
    logic                    skip, accept, last_word;
    logic [3:0]              row_q;
    logic [1:0]              word_q;
    logic [ADDR_WIDTH-1:0]   row_base_q, pitch_q;
    logic [ADDR_WIDTH-1:0]   calc_addr, calc_pitch;
    logic                    calc_hx, calc_hy;
    logic [1:0]              calc_xoff, calc_words;

    m2vrefaddr_coord #(
        .MVH_WIDTH (MVH_WIDTH),
        .MVV_WIDTH (MVV_WIDTH),
        .MBX_WIDTH (MBX_WIDTH),
        .MBY_WIDTH (MBY_WIDTH),
        .FRAME_MBW (FRAME_MBW),
        .FRAME_MBH (FRAME_MBH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_coord (
        .blk       (s1_block),
        .mb_x      (s1_mb_x),
        .mb_y      (s1_mb_y),
        .mv_h      (s1_mv_h),
        .mv_v      (s1_mv_v),
        .start_addr(calc_addr),
        .pitch     (calc_pitch),
        .hx        (calc_hx),
        .hy        (calc_hy),
        .xoff      (calc_xoff),
        .words     (calc_words)
    );

    assign skip      = sa_iframe | s1_mb_intra | ~s1_enable | (s1_block > BLK_LAST);
    assign accept    = (state_q == ST_REQ) && !rd_wait;
    assign last_word = (row_q == (pf_hy ? 4'd8 : 4'd7)) && (word_q == pf_words - 2'd1);

    // Status outputs decode straight from the state register, so they are
    // 0 in the cycle after reset without extra flops.
    assign rd_req = (state_q == ST_REQ);
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)                state_d = ST_CALC;
            ST_CALC: state_d = skip ? ST_DONE : ST_REQ;
            ST_REQ:  if (accept && last_word)  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            word_q      <= '0;
            row_base_q  <= '0;
            pitch_q     <= '0;
            rd_addr     <= '0;
            pf_hx       <= 1'b0;
            pf_hy       <= 1'b0;
            pf_xoff     <= '0;
            pf_words    <= '0;
            err_overrun <= 1'b0;
        end else begin
            state_q <= state_d;

            if (start && (state_q != ST_IDLE))
                err_overrun <= 1'b1;

            if (state_q == ST_CALC) begin
                pf_hx      <= calc_hx;
                pf_hy      <= calc_hy;
                pf_xoff    <= calc_xoff;
                pf_words   <= calc_words;
                pitch_q    <= calc_pitch;
                row_base_q <= calc_addr;
                rd_addr    <= calc_addr;
                row_q      <= '0;
                word_q     <= '0;
            end else if (accept) begin
                // Row base accumulates the pitch: no multiplier in the fetch loop
                if (word_q == pf_words - 2'd1) begin
                    word_q     <= '0;
                    row_q      <= row_q + 4'd1;
                    row_base_q <= row_base_q + pitch_q;
                    rd_addr    <= row_base_q + pitch_q;
                end else begin
                    word_q  <= word_q + 2'd1;
                    rd_addr <= rd_addr + 1'b1;
                end
            end
        end
    end

endmodule
